// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, key codes and status bytes for the lock sequencer
package lock_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_REPORT  = 3'd3;
  localparam logic [2:0] S_BLINK   = 3'd4;
  localparam logic [2:0] S_OPEN    = 3'd5;
  localparam logic [2:0] S_LOCKOUT = 3'd6;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [7:0] ST_PASS = 8'h50;
  localparam logic [7:0] ST_FAIL = 8'h46;
  localparam logic [7:0] ST_LOCK = 8'h4C;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/lock_sequencer_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a rising-edge pulse
module sync_edge (
  input  logic hwclk,
  input  logic rstn,
  input  logic d,
  output logic rise
);
  logic [2:0] s;
  // s[1:0] resynchronise d, s[2] holds the previous synchronised value
  always_ff @(posedge hwclk or negedge rstn)
    if (!rstn) s <= '0;
    else s <= {s[1:0], d};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad code entry, secret check, UART/blinker sequencing and lock timing
module lock_sequencer #(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] SECRET         = 32'h0000_1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 60000000,
  parameter int          LOCKOUT_CYCLES = 120000000
) (
  input  logic       hwclk,
  input  logic       rstn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       blink_done,
  input  logic       tx_done,
  output logic       blink_start,
  output logic       blink_type,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_count
);
  import lock_pkg::*;
  localparam int BW = 4 * CODE_LEN;
  localparam int MAXC = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int CW = $clog2(MAXC) < 1 ? 1 : $clog2(MAXC);
  localparam logic [3:0] CL = 4'(CODE_LEN);
  logic [2:0] state;
  logic [BW-1:0] code_buf;
  logic [3:0] count;
  logic ovf;
  logic [CW-1:0] timer;
  logic tx_rise, blink_rise, pass, lock_hit, digit, clear;
  logic [2:0] fc_inc;
  sync_edge u_tx_sync (.hwclk(hwclk), .rstn(rstn), .d(tx_done), .rise(tx_rise));
  sync_edge u_blink_sync (.hwclk(hwclk), .rstn(rstn), .d(blink_done), .rise(blink_rise));
  assign digit = key_valid && is_digit(key_code);
  assign clear = key_valid && key_code == KEY_CLEAR;
  assign pass = count == CL && !ovf && code_buf == SECRET[BW-1:0];
  assign fc_inc = {1'b0, fail_count} + 3'd1;
  assign lock_hit = int'(fc_inc) == MAX_TRIES;
  // Sequencer: entry assembly, check, report/blink handshakes and the shared open/lockout timer
  always_ff @(posedge hwclk or negedge rstn)
    if (!rstn) begin
      state <= S_IDLE;
      code_buf <= '0;
      count <= '0;
      ovf <= 1'b0;
      timer <= '0;
      fail_count <= '0;
      tx_byte <= '0;
      tx_send <= 1'b0;
      blink_start <= 1'b0;
      blink_type <= 1'b0;
      unlocked <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      blink_start <= 1'b0;
      case (state)
        S_IDLE: if (digit) begin
          code_buf <= BW'(key_code);
          count <= 4'd1;
          ovf <= 1'b0;
          state <= S_ENTRY;
        end
        S_ENTRY: if (digit) begin
          code_buf <= BW'({code_buf, key_code});
          if (count == CL) ovf <= 1'b1;
          else count <= count + 4'd1;
        end else if (clear) begin
          code_buf <= '0;
          count <= '0;
          ovf <= 1'b0;
          state <= S_IDLE;
        end else if (key_valid && key_code == KEY_ENTER) state <= S_CHECK;
        S_CHECK: begin
          tx_byte <= pass ? ST_PASS : lock_hit ? ST_LOCK : ST_FAIL;
          fail_count <= pass ? 2'd0 : fail_count == 2'd3 ? 2'd3 : fail_count + 2'd1;
          code_buf <= '0;
          count <= '0;
          ovf <= 1'b0;
          tx_send <= 1'b1;
          state <= S_REPORT;
        end
        S_REPORT: if (tx_rise) begin
          tx_send <= 1'b0;
          blink_start <= 1'b1;
          blink_type <= tx_byte == ST_PASS;
          state <= S_BLINK;
        end
        S_BLINK: if (blink_rise) begin
          if (blink_type) begin
            unlocked <= 1'b1;
            timer <= CW'(UNLOCK_CYCLES - 1);
            state <= S_OPEN;
          end else if (tx_byte == ST_LOCK) begin
            locked_out <= 1'b1;
            fail_count <= 2'd0;
            timer <= CW'(LOCKOUT_CYCLES - 1);
            state <= S_LOCKOUT;
          end else state <= S_IDLE;
        end
        S_OPEN: if (clear || timer == '0) begin
          unlocked <= 1'b0;
          state <= S_IDLE;
        end else timer <= timer - CW'(1);
        S_LOCKOUT: if (timer == '0) begin
          locked_out <= 1'b0;
          state <= S_IDLE;
        end else timer <= timer - CW'(1);
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: table, hand-written and random code attempts against a digit-list model
module tb_lock_sequencer;
  import lock_pkg::*;
  typedef struct {
    int          n;
    logic [31:0] keys;
    logic [7:0]  eb;
    logic [1:0]  efc;
  } vec_t;
  logic hwclk = 0, rstn = 0, key_valid = 0, blink_done = 0, tx_done = 0;
  logic [3:0] key_code = 0;
  logic blink_start, blink_type, tx_send, unlocked, locked_out;
  logic [7:0] tx_byte;
  logic [1:0] fail_count;
  int checks = 0, failures = 0;
  int urun = 0, lrun = 0, last_u = 0, last_l = 0, tx_rises = 0;
  logic tx_prev = 0;
  int model_fc = 0;
  vec_t tbl [8];

  always #5 hwclk = ~hwclk;

  lock_sequencer #(.CODE_LEN(4), .SECRET(32'h0000_1234), .MAX_TRIES(3),
                   .UNLOCK_CYCLES(50), .LOCKOUT_CYCLES(100)) dut (
    .hwclk(hwclk), .rstn(rstn), .key_valid(key_valid), .key_code(key_code),
    .blink_done(blink_done), .tx_done(tx_done), .blink_start(blink_start),
    .blink_type(blink_type), .tx_byte(tx_byte), .tx_send(tx_send),
    .unlocked(unlocked), .locked_out(locked_out), .fail_count(fail_count));

  always @(negedge hwclk) begin
    if (unlocked) urun++;
    else if (urun != 0) begin last_u = urun; urun = 0; end
    if (locked_out) lrun++;
    else if (lrun != 0) begin last_l = lrun; lrun = 0; end
    if (tx_send && !tx_prev) tx_rises++;
    tx_prev = tx_send;
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic press(logic [3:0] k);
    @(negedge hwclk);
    key_valid = 1;
    key_code = k;
    @(negedge hwclk);
    key_valid = 0;
  endtask

  task automatic serve(string nm, logic [7:0] eb, logic [1:0] efc, bit pre);
    int t = 0;
    while (!tx_send && t < 20) begin @(negedge hwclk); t++; end
    chk({nm, ":tx_send"}, tx_send, 1);
    chk({nm, ":tx_byte"}, tx_byte, eb);
    chk({nm, ":fail_count"}, fail_count, efc);
    repeat (6) @(negedge hwclk);
    chk({nm, ":tx_hold"}, tx_send, 1);
    if (pre) begin
      tx_done = 0;
      repeat (4) @(negedge hwclk);
      chk({nm, ":tx_hold_pre"}, tx_send, 1);
    end
    tx_done = 1;
    t = 0;
    while (tx_send && t < 10) begin @(negedge hwclk); t++; end
    chk({nm, ":tx_drop"}, tx_send, 0);
    chk({nm, ":blink_start"}, blink_start, 1);
    chk({nm, ":blink_type"}, blink_type, eb == ST_PASS);
    @(negedge hwclk);
    chk({nm, ":blink_pulse"}, blink_start, 0);
    tx_done = 0;
  endtask

  task automatic finish_blink(string nm, logic [7:0] eb, logic [1:0] efc);
    int t = 0, r;
    repeat (5) @(negedge hwclk);
    blink_done = 1;
    if (eb == ST_PASS) begin
      while (!unlocked && t < 10) begin @(negedge hwclk); t++; end
      chk({nm, ":unlocked"}, unlocked, 1);
      t = 0;
      while (unlocked && t < 80) begin @(negedge hwclk); t++; end
      repeat (2) @(negedge hwclk);
      chk({nm, ":open_len"}, last_u, 50);
      chk({nm, ":fc_after"}, fail_count, 0);
    end else if (eb == ST_LOCK) begin
      while (!locked_out && t < 10) begin @(negedge hwclk); t++; end
      chk({nm, ":locked_out"}, locked_out, 1);
      r = tx_rises;
      press(1); press(2); press(3); press(4); press(KEY_ENTER);
      chk({nm, ":lock_hold"}, locked_out, 1);
      t = 0;
      while (locked_out && t < 150) begin @(negedge hwclk); t++; end
      repeat (3) @(negedge hwclk);
      chk({nm, ":lock_len"}, last_l, 100);
      chk({nm, ":keys_ignored"}, tx_rises, r);
      chk({nm, ":fc_after"}, fail_count, 0);
    end else begin
      repeat (10) @(negedge hwclk);
      chk({nm, ":no_unlock"}, {unlocked, locked_out, tx_send}, 0);
      chk({nm, ":fc_after"}, fail_count, efc);
    end
    blink_done = 0;
    repeat (4) @(negedge hwclk);
  endtask

  task automatic reset_check(string nm);
    @(negedge hwclk);
    rstn = 0;
    #1;
    chk({nm, ":outs"}, {tx_send, blink_start, blink_type, unlocked, locked_out}, 0);
    chk({nm, ":fc"}, fail_count, 0);
    chk({nm, ":tx_byte"}, tx_byte, 0);
    tx_done = 0;
    blink_done = 0;
    repeat (2) @(negedge hwclk);
    rstn = 1;
    model_fc = 0;
    repeat (2) @(negedge hwclk);
  endtask

  function automatic logic [7:0] model_attempt(int q[$]);
    bit ok = q.size() == 4;
    for (int i = 0; i < q.size() && ok; i++)
      ok = q[i] == ((32'h1234 >> (4 * (3 - i))) & 32'hF);
    if (ok) begin model_fc = 0; return ST_PASS; end
    model_fc = model_fc == 3 ? 3 : model_fc + 1;
    return model_fc == 3 ? ST_LOCK : ST_FAIL;
  endfunction

  initial begin
    int q[$];
    logic [7:0] eb;
    logic [1:0] efc;
    tbl[0] = '{5, 32'h0001234B, ST_PASS, 2'd0};
    tbl[1] = '{4, 32'h0000123B, ST_FAIL, 2'd1};
    tbl[2] = '{6, 32'h0012345B, ST_FAIL, 2'd2};
    tbl[3] = '{8, 32'h99A1234B, ST_PASS, 2'd0};
    tbl[4] = '{5, 32'h0004321B, ST_FAIL, 2'd1};
    tbl[5] = '{6, 32'h0001234B, ST_FAIL, 2'd2};
    tbl[6] = '{5, 32'h0001235B, ST_LOCK, 2'd3};
    tbl[7] = '{6, 32'h00C1234B, ST_PASS, 2'd0};
    repeat (3) @(negedge hwclk);
    chk("reset:outs", {tx_send, blink_start, blink_type, unlocked, locked_out}, 0);
    chk("reset:tx_byte", tx_byte, 0);
    chk("reset:fc", fail_count, 0);
    rstn = 1;
    repeat (2) @(negedge hwclk);
    for (int i = 0; i < 8; i++) begin
      string nm = $sformatf("tbl%0d", i);
      for (int j = tbl[i].n - 1; j >= 0; j--) press(tbl[i].keys[4*j +: 4]);
      serve(nm, tbl[i].eb, tbl[i].efc, 0);
      finish_blink(nm, tbl[i].eb, tbl[i].eb == ST_LOCK ? 2'd0 : tbl[i].efc);
    end
    tx_done = 1;
    repeat (6) @(negedge hwclk);
    press(1); press(2); press(3); press(4); press(KEY_ENTER);
    serve("pre_tx", ST_PASS, 2'd0, 1);
    finish_blink("pre_tx", ST_PASS, 2'd0);
    press(1); press(2); press(3); press(4); press(KEY_ENTER);
    serve("rst_pass", ST_PASS, 2'd0, 0);
    repeat (2) @(negedge hwclk);
    reset_check("rst_pass");
    press(7); press(KEY_ENTER);
    serve("rst_f1", ST_FAIL, 2'd1, 0);
    finish_blink("rst_f1", ST_FAIL, 2'd1);
    press(7); press(KEY_ENTER);
    serve("rst_f2", ST_FAIL, 2'd2, 0);
    repeat (2) @(negedge hwclk);
    reset_check("rst_f2");
    press(1); press(2); press(3); press(4); press(KEY_ENTER);
    serve("after_rst", ST_PASS, 2'd0, 0);
    finish_blink("after_rst", ST_PASS, 2'd0);
    model_fc = 0;
    for (int it = 0; it < 14; it++) begin
      string nm = $sformatf("rnd%0d", it);
      q.delete();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) press(4'($urandom_range(0, 9)));
        press(KEY_CLEAR);
      end
      if ($urandom_range(0, 2) == 0) q = '{1, 2, 3, 4};
      else repeat ($urandom_range(1, 6)) q.push_back($urandom_range(0, 9));
      foreach (q[k]) press(4'(q[k]));
      press(KEY_ENTER);
      eb = model_attempt(q);
      efc = 2'(model_fc);
      serve(nm, eb, efc, 0);
      if (eb == ST_LOCK) model_fc = 0;
      finish_blink(nm, eb, 2'(model_fc));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Central controller for the digital lock. It consumes decoded keypad events and assembles a code entry, then compares it against a parameterised secret. It sequences the shared UART transmitter (status byte report) and the LED blinker (pass/fail pattern). It owns the lock state (unlocked window, failed-attempt count, lockout timer) and sits between the keypad decoder and the blinker/UART blocks in top.

Parameters:
CODE_LEN, 4, number of digits in the secret (1..8)
SECRET, 32'h0000_1234, secret digits as 4-bit nibbles; the low CODE_LEN nibbles are used, last-entered digit in nibble 0
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
UNLOCK_CYCLES, 60000000, hwclk cycles the lock stays open (5 s at 12 MHz)
LOCKOUT_CYCLES, 120000000, hwclk cycles keys are ignored after MAX_TRIES failures

Ports:
hwclk  in  1  system clock, 12 MHz
rstn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse (hwclk domain): key_code is valid
key_code  in  4  0-9 digit; 4'hA clear; 4'hB enter; 4'hC-4'hF ignored
blink_done  in  1  blinker finished; asynchronous level, synchronised internally
tx_done  in  1  UART byte finished; 9600 Hz domain, synchronised internally
blink_start  out  1  one-cycle pulse requesting a blink pattern
blink_type  out  1  0 = fail pattern, 1 = pass pattern; stable from blink_start until blink_done edge
tx_byte  out  8  status byte; stable while tx_send is high
tx_send  out  1  level request to the UART
unlocked  out  1  high while the lock is open
locked_out  out  1  high during lockout
fail_count  out  2  consecutive failures so far (saturates at 3)

Behaviour:
- Reset (async, rstn low): state IDLE; all outputs 0; tx_byte 8'h00; entry buffer, digit count and overflow flag cleared; synchroniser flops cleared.
- blink_done and tx_done each pass through a 2-flop synchroniser plus an edge detector. Only rising edges are used.
- States: IDLE, ENTRY, CHECK, REPORT, BLINK, OPEN, LOCKOUT.
- IDLE: a digit key loads the buffer and sets count=1, then goes to ENTRY. Clear and enter are ignored.
- ENTRY digit: buffer shifts left by 4 and the new digit enters nibble 0. The count saturates at CODE_LEN; a digit arriving with count==CODE_LEN sets the overflow flag.
- ENTRY clear: buffer, count and overflow are cleared; state returns to IDLE.
- ENTRY enter: go to CHECK.
- CHECK (exactly 1 cycle) computes pass = (count==CODE_LEN) && !overflow && (buffer nibbles == SECRET nibbles).
  - On pass: fail_count is cleared and the status byte is 8'h50 ('P').
  - On fail: fail_count increments and the status byte is 8'h46 ('F'). If the incremented value == MAX_TRIES, the status byte is instead 8'h4C ('L').
  - Buffer, count and overflow are cleared. State goes to REPORT.
- REPORT: tx_byte is loaded on entry and tx_send is high from the first REPORT cycle. On the synchronised tx_done rising edge, tx_send drops and blink_start pulses with blink_type = pass. State goes to BLINK.
- BLINK: wait for the synchronised blink_done rising edge, then:
  - pass: go to OPEN.
  - 'L': go to LOCKOUT and clear fail_count.
  - otherwise: go to IDLE.
- OPEN: unlocked=1 for exactly UNLOCK_CYCLES cycles, then IDLE. A clear key relocks immediately.
- LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, then IDLE.
- key_valid is ignored in CHECK, REPORT, BLINK and LOCKOUT. It is not queued.
- A single down-counter is shared by OPEN and LOCKOUT. It is loaded on state entry and its width is $clog2 of the larger parameter.
- If tx_done is already high when REPORT is entered, only a fresh rising edge completes the request.
- Reset mid-REPORT/BLINK drops tx_send and blink_type at once. No partial state survives.

Decomposition:
- Shared package (lock_pkg) holds:
  - state encoding
  - key codes KEY_CLEAR=4'hA and KEY_ENTER=4'hB
  - status bytes ST_PASS=8'h50, ST_FAIL=8'h46, ST_LOCK=8'h4C
- One sub-module: sync_edge (2-flop synchroniser + rising-edge pulse, async active-low reset), instantiated twice.

Test Plan:
All scenarios use SECRET=32'h1234, CODE_LEN=4, MAX_TRIES=3, UNLOCK_CYCLES=50, LOCKOUT_CYCLES=100, with UART and blinker models.
- Keys 1,2,3,4,enter -> tx_byte=8'h50 with tx_send held until the tx_done edge; then a blink_start pulse with blink_type=1; after blink_done, unlocked=1 for exactly 50 cycles; fail_count=0.
- Keys 1,2,3,enter (short) and keys 1,2,3,4,5,enter (overflow) -> each reports 8'h46 with blink_type=0; fail_count goes 1 then 2; unlocked stays 0.
- Three consecutive wrong codes -> third report is 8'h4C; after blink_done, locked_out=1 for exactly 100 cycles; key presses during that window cause no response; fail_count=0 afterwards.
- Keys 9,9, clear, 1,2,3,4, enter -> pass ('P'); clear discards the partial entry.
- tx_done held high before REPORT, then dropped and re-raised -> tx_send deasserts only after the new rising edge.
- rstn pulled low during BLINK -> tx_send, blink_start, unlocked, locked_out and fail_count are 0 immediately; the next correct code unlocks normally.
